int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: irq  input  8  external interrupt lines, asynchronous; bit 7 highest priority.
REQ-004 SHALL have port: mask_we  input  1  mask register write enable.
REQ-005 SHALL have port: mask_d  input  8  mask write data; 1 = line enabled.
REQ-006 SHALL have port: calli  input  8  one-hot accept vector from control unit; 0 = no accept.
REQ-007 SHALL have port: reti  input  8  one-hot return vector from control unit; 0 = no return.
REQ-008 SHALL have port: data_s  output  8  request vector (pending AND mask, gated per REQ-015/REQ-024).
REQ-009 SHALL have port: int_a  output  8  in-service register.
REQ-010 SHALL have port: depth  output  4  count of in-service bits, 0..8.
REQ-011 SHALL have port: err  output  1  sticky protocol error flag.

Function
REQ-012 SHALL pass each irq bit through a 2-FF synchronizer plus a delay FF; rising edge = sync2 AND NOT delay.
REQ-013 SHALL set pending[i] on the clock edge following the detected rising edge: irq sampled high at edge k -> pending[i]=1 after edge k+2; level held high SHALL not re-set pending.
REQ-014 SHALL load mask from mask_d when mask_we=1; masked lines still set pending, only data_s is gated.
REQ-015 SHALL drive data_s = pending & mask, forced to 8'h00 while FSM is in LOCK.
REQ-016 SHALL treat calli as valid only if one-hot, equal to the highest set bit of data_s, and greater than the highest set bit of int_a (int_a=0 counts as 0).
REQ-017 On valid calli: pending[i] cleared, int_a[i] set, depth incremented, FSM -> LOCK for exactly one cycle.
REQ-018 On invalid nonzero calli: no state change, err set.
REQ-019 SHALL treat reti as valid only if one-hot and equal to the highest set bit of int_a; on valid reti: int_a[i] cleared, depth decremented; on invalid nonzero reti: no state change, err set.
REQ-020 FSM states: IDLE (int_a=0), ACTIVE (int_a!=0), LOCK (one cycle after accept); IDLE/ACTIVE -> LOCK on valid calli; LOCK -> ACTIVE unconditionally; ACTIVE -> IDLE on valid reti leaving int_a=0.
REQ-021 In LOCK, calli SHALL be ignored without setting err; reti SHALL be processed normally.
REQ-022 Simultaneous new edge and valid accept on same line: pending SHALL remain 1 (set wins).
REQ-023 Simultaneous valid calli and valid reti: reti evaluated against int_a before the cycle, calli validity against int_a after reti removal; both applied, depth net unchanged.

Reset
REQ-024 While reset=0: sync/delay FFs, pending, int_a, mask SHALL be 8'h00; depth=0; err=0; FSM=IDLE; data_s=8'h00; asserting reset mid-service SHALL discard all in-service and pending state immediately.
REQ-025 First irq edge SHALL be detectable no earlier than the third rising clk edge after reset deassertion; lines high at reset release SHALL register as an edge.

Configuration
REQ-026 Macro INTC_NESTING_EN defined: higher-priority request preempts service per REQ-016, depth up to 8.
REQ-027 Macro INTC_NESTING_EN undefined: data_s SHALL be forced to 8'h00 while int_a!=0; depth never exceeds 1; any calli while int_a!=0 SHALL set err.

Verification
REQ-028 Reset, mask=8'hFF, irq[3] rises -> data_s=8'h08 after 2nd edge post-sample; calli=8'h08 -> int_a=8'h08, depth=1, data_s=8'h00 in LOCK.
REQ-029 INTC_NESTING_EN: in service of line 3, irq[6] rises -> data_s=8'h40; calli=8'h40 -> int_a=8'h48, depth=2; reti=8'h40 then 8'h08 -> int_a=8'h00, FSM IDLE.
REQ-030 In service of line 6, irq[2] rises -> data_s=8'h04 held; calli=8'h04 -> err=1, int_a unchanged 8'h40.
REQ-031 mask=8'h00, irq[5] rises -> data_s=8'h00; mask_we with 8'h20 -> data_s=8'h20 next cycle.
REQ-032 Accept of line 1 same cycle as new edge on irq[1] -> int_a[1]=1, pending[1]=1; reti=8'h01 while int_a=8'h02 -> err=1.
REQ-033 reset pulsed low with int_a=8'h48, depth=2 -> int_a=8'h00, depth=0, err=0 immediately, asynchronously.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: 8-line priority interrupt controller (bit 7 highest) with in-service tracking.
// Define INTC_NESTING_EN to let higher-priority requests preempt an active service.
module int_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] irq,
   input  logic       mask_we,
   input  logic [7:0] mask_d,
   input  logic [7:0] calli,
   input  logic [7:0] reti,
   output logic [7:0] data_s,
   output logic [7:0] int_a,
   output logic [3:0] depth,
   output logic       err
);
   localparam int unsigned N  = 8;
   localparam int unsigned DW = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_LOCK   = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;

   logic [N-1:0]   r_sync1;
   logic [N-1:0]   r_sync2;
   logic [N-1:0]   r_dly;
   logic [N-1:0]   r_pend;
   logic [N-1:0]   r_mask;
   logic [N-1:0]   r_int_a;
   logic [N-1:0]   r_data_s;
   logic [DW-1:0]  r_depth;
   logic           r_err;

   logic [N-1:0]   w_rise;
   logic [N-1:0]   w_acc;
   logic [N-1:0]   w_ret;
   logic [N-1:0]   w_int_ret;
   logic [N-1:0]   w_pend_nxt;
   logic [N-1:0]   w_mask_nxt;
   logic [N-1:0]   w_int_a_nxt;
   logic [N-1:0]   w_data_s_nxt;
   logic [DW-1:0]  w_depth_nxt;
   logic           w_err_nxt;
   logic           w_call_ok;
   logic           w_ret_ok;

   // One-hot vector of the highest set bit (zero in, zero out).
   function automatic logic [N-1:0] msb_of(input logic [N-1:0] v);
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            m    = '0;
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

   function automatic logic is_onehot(input logic [N-1:0] v);
      return (v != '0) && ((v & (v - N'(1))) == '0);
   endfunction

   assign data_s = r_data_s;
   assign int_a  = r_int_a;
   assign depth  = r_depth;
   assign err    = r_err;

   // Next-state and datapath: returns are resolved before accepts are judged.
   always_comb begin
      w_state_nxt  = r_state;
      w_acc        = '0;
      w_ret        = '0;
      w_err_nxt    = r_err;
      w_rise       = r_sync2 & ~r_dly;
      w_mask_nxt   = mask_we ? mask_d : r_mask;

      w_ret_ok = is_onehot(reti) && (reti == msb_of(r_int_a));
      if (w_ret_ok) begin
         w_ret = reti;
      end else if (reti != '0) begin
         w_err_nxt = 1'b1;
      end
      w_int_ret = r_int_a & ~w_ret;

      w_call_ok = (r_state != S_LOCK) && is_onehot(calli) &&
                  (calli == msb_of(r_data_s)) && (calli > msb_of(w_int_ret));
`ifndef INTC_NESTING_EN
      w_call_ok = w_call_ok && (r_int_a == '0);
`endif
      if (w_call_ok) begin
         w_acc = calli;
      end else if ((r_state != S_LOCK) && (calli != '0)) begin
         w_err_nxt = 1'b1;
      end

      // A fresh edge on a line being accepted keeps it pending.
      w_pend_nxt  = (r_pend & ~w_acc) | w_rise;
      w_int_a_nxt = w_int_ret | w_acc;
      w_depth_nxt = r_depth + DW'(w_call_ok) - DW'(w_ret_ok);

      case (r_state)
         S_LOCK:  w_state_nxt = S_ACTIVE;
         default: w_state_nxt = (w_int_a_nxt == '0) ? S_IDLE : S_ACTIVE;
      endcase
      if (w_call_ok) begin
         w_state_nxt = S_LOCK;
      end

      w_data_s_nxt = w_pend_nxt & w_mask_nxt;
      if (w_state_nxt == S_LOCK) begin
         w_data_s_nxt = '0;
      end
`ifndef INTC_NESTING_EN
      if (w_int_a_nxt != '0) begin
         w_data_s_nxt = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_dly    <= '0;
         r_pend   <= '0;
         r_mask   <= '0;
         r_int_a  <= '0;
         r_data_s <= '0;
         r_depth  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_sync1  <= irq;
         r_sync2  <= r_sync1;
         r_dly    <= r_sync2;
         r_pend   <= w_pend_nxt;
         r_mask   <= w_mask_nxt;
         r_int_a  <= w_int_a_nxt;
         r_data_s <= w_data_s_nxt;
         r_depth  <= w_depth_nxt;
         r_err    <= w_err_nxt;
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized traffic against a
// stack-based reference model; builds with or without INTC_NESTING_EN.
module tb_int_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] irq = '0;
   logic       mask_we = 1'b0;
   logic [7:0] mask_d = '0;
   logic [7:0] calli = '0;
   logic [7:0] reti = '0;
   logic [7:0] data_s;
   logic [7:0] int_a;
   logic [3:0] depth;
   logic       err;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model: pending/mask bit sets, in-service stack of line numbers.
   logic [7:0] m_pend, m_mask, m_ds;
   logic [7:0] s1, s2, s3;
   int         stk[$];
   bit         m_lock, m_err;

   int_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .irq     (irq),
      .mask_we (mask_we),
      .mask_d  (mask_d),
      .calli   (calli),
      .reti    (reti),
      .data_s  (data_s),
      .int_a   (int_a),
      .depth   (depth),
      .err     (err)
   );

   always #5 clk = ~clk;

   function automatic int top_line(input logic [7:0] v);
      int r = -1;
      for (int i = 0; i < 8; i++) if (v[i]) r = i;
      return r;
   endfunction

   function automatic int onehot_idx(input logic [7:0] v);
      int cnt = 0;
      int idx = -1;
      for (int i = 0; i < 8; i++) if (v[i]) begin cnt++; idx = i; end
      return (cnt == 1) ? idx : -1;
   endfunction

   function automatic logic [7:0] m_int_a();
      logic [7:0] r = '0;
      foreach (stk[i]) r[stk[i]] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '0; m_ds = '0;
      s1 = '0; s2 = '0; s3 = '0;
      stk.delete();
      m_lock = 1'b0; m_err = 1'b0;
   endtask

   // One rising clock edge; the model consumes the inputs the DUT sampled.
   task automatic tick();
      int top, topa, ri, ci;
      bit new_lock;
      @(posedge clk);
      if (reset) begin
         top = (stk.size() > 0) ? stk[$] : -1;
         ri  = onehot_idx(reti);
         if (reti != 0) begin
            if (ri >= 0 && ri == top) void'(stk.pop_back());
            else m_err = 1'b1;
         end
         topa     = (stk.size() > 0) ? stk[$] : -1;
         ci       = onehot_idx(calli);
         new_lock = 1'b0;
         if (!m_lock && calli != 0) begin
            if (ci >= 0 && ci == top_line(m_ds) && ci > topa) begin
               stk.push_back(ci);
               m_pend[ci] = 1'b0;
               new_lock   = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end
         m_pend = m_pend | (s2 & ~s3);
         s3 = s2; s2 = s1; s1 = irq;
         if (mask_we) m_mask = mask_d;
         m_lock = new_lock;
         m_ds   = m_lock ? 8'h00 : (m_pend & m_mask);
`ifndef INTC_NESTING_EN
         if (stk.size() > 0) m_ds = 8'h00;
`endif
      end
      #1;
   endtask

   task automatic apply_reset();
      irq = '0; calli = '0; reti = '0; mask_we = 1'b0; mask_d = '0;
      reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      model_reset();
      #1;
      n_checks++; if (data_s !== 8'h00) begin n_errors++; $display("FAIL reset_data_s: got %h want 00", data_s); end
      n_checks++; if (int_a !== 8'h00)  begin n_errors++; $display("FAIL reset_int_a: got %h want 00", int_a); end
      n_checks++; if (depth !== 4'd0)   begin n_errors++; $display("FAIL reset_depth: got %0d want 0", depth); end
      n_checks++; if (err !== 1'b0)     begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
      irq = 8'hFF;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      mask_we = 1'b1; mask_d = 8'hFF;
      tick();
      mask_we = 1'b0;
      tick();
      n_checks++; if (data_s !== 8'h00) begin n_errors++; $display("FAIL release_early: got %h want 00", data_s); end
      tick();
      n_checks++; if (data_s !== 8'hFF) begin n_errors++; $display("FAIL release_high_edge: got %h want ff", data_s); end
   endtask

   task automatic test_basic();
      apply_reset();
      mask_we = 1'b1; mask_d = 8'hFF; tick(); mask_we = 1'b0;
      irq = 8'h08; tick();
      n_checks++; if (data_s !== 8'h00) begin n_errors++; $display("FAIL basic_lat1: got %h want 00", data_s); end
      tick();
      n_checks++; if (data_s !== 8'h00) begin n_errors++; $display("FAIL basic_lat2: got %h want 00", data_s); end
      tick();
      n_checks++; if (data_s !== 8'h08) begin n_errors++; $display("FAIL basic_req: got %h want 08", data_s); end
      tick();
      n_checks++; if (data_s !== 8'h08) begin n_errors++; $display("FAIL basic_level_hold: got %h want 08", data_s); end
      calli = 8'h08; tick(); calli = 8'h00;
      n_checks++; if (int_a !== 8'h08)  begin n_errors++; $display("FAIL basic_int_a: got %h want 08", int_a); end
      n_checks++; if (depth !== 4'd1)   begin n_errors++; $display("FAIL basic_depth: got %0d want 1", depth); end
      n_checks++; if (data_s !== 8'h00) begin n_errors++; $display("FAIL basic_lock_ds: got %h want 00", data_s); end
      n_checks++; if (err !== 1'b0)     begin n_errors++; $display("FAIL basic_err: got %b want 0", err); end
   endtask

   task automatic test_nesting();
      apply_reset();
      mask_we = 1'b1; mask_d = 8'hFF; tick(); mask_we = 1'b0;
      irq = 8'h08; repeat (3) tick();
      calli = 8'h08; tick(); calli = 8'h00; tick();
      irq = 8'h48; repeat (3) tick();
      n_checks++; if (data_s !== m_ds) begin n_errors++; $display("FAIL nest_req: got %h want %h", data_s, m_ds); end
`ifdef INTC_NESTING_EN
      n_checks++; if (data_s !== 8'h40) begin n_errors++; $display("FAIL nest_req6: got %h want 40", data_s); end
`endif
      calli = 8'h40; tick(); calli = 8'h00;
      n_checks++; if (int_a !== m_int_a()) begin n_errors++; $display("FAIL nest_int_a: got %h want %h", int_a, m_int_a()); end
      n_checks++; if (depth !== 4'(stk.size())) begin n_errors++; $display("FAIL nest_depth: got %0d want %0d", depth, stk.size()); end
`ifdef INTC_NESTING_EN
      n_checks++; if (int_a !== 8'h48 || depth !== 4'd2) begin n_errors++; $display("FAIL nest_48: got %h/%0d want 48/2", int_a, depth); end
`endif
      tick();
      reti = 8'h40; tick(); reti = 8'h08; tick(); reti = 8'h00;
      n_checks++; if (int_a !== 8'h00) begin n_errors++; $display("FAIL nest_unwind: got %h want 00", int_a); end
      n_checks++; if (depth !== 4'd0)  begin n_errors++; $display("FAIL nest_unwind_depth: got %0d want 0", depth); end
      irq = 8'h00; repeat (3) tick();
      irq = 8'h40; repeat (3) tick();
      calli = 8'h40; tick(); calli = 8'h00; tick();
      irq = 8'h44; repeat (3) tick();
      n_checks++; if (data_s !== m_ds) begin n_errors++; $display("FAIL low_req: got %h want %h", data_s, m_ds); end
      calli = 8'h04; tick(); calli = 8'h00;
      n_checks++; if (err !== 1'b1)    begin n_errors++; $display("FAIL low_err: got %b want 1", err); end
      n_checks++; if (int_a !== 8'h40) begin n_errors++; $display("FAIL low_int_a: got %h want 40", int_a); end
   endtask

   task automatic test_mask();
      apply_reset();
      irq = 8'h20; repeat (3) tick();
      n_checks++; if (data_s !== 8'h00) begin n_errors++; $display("FAIL mask_gate: got %h want 00", data_s); end
      mask_we = 1'b1; mask_d = 8'h20; tick(); mask_we = 1'b0;
      n_checks++; if (data_s !== 8'h20) begin n_errors++; $display("FAIL mask_open: got %h want 20", data_s); end
   endtask

   task automatic test_set_wins();
      apply_reset();
      mask_we = 1'b1; mask_d = 8'hFF; tick(); mask_we = 1'b0;
      irq = 8'h02; tick(); irq = 8'h00; tick(); irq = 8'h02; tick();
      n_checks++; if (data_s !== 8'h02) begin n_errors++; $display("FAIL sw_req: got %h want 02", data_s); end
      tick();
      calli = 8'h02; tick(); calli = 8'h00;
      n_checks++; if (int_a !== 8'h02) begin n_errors++; $display("FAIL sw_int_a: got %h want 02", int_a); end
      reti = 8'h01; tick();
      n_checks++; if (err !== 1'b1)    begin n_errors++; $display("FAIL sw_bad_reti: got %b want 1", err); end
      n_checks++; if (int_a !== 8'h02) begin n_errors++; $display("FAIL sw_int_a_kept: got %h want 02", int_a); end
      reti = 8'h02; tick(); reti = 8'h00;
      n_checks++; if (int_a !== 8'h00)  begin n_errors++; $display("FAIL sw_ret: got %h want 00", int_a); end
      n_checks++; if (data_s !== 8'h02) begin n_errors++; $display("FAIL sw_pend_kept: got %h want 02", data_s); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      mask_we = 1'b1; mask_d = 8'hFF; tick(); mask_we = 1'b0;
      irq = 8'h08; repeat (3) tick();
      calli = 8'h08; tick(); calli = 8'h00;
      reti = 8'h80; tick(); reti = 8'h00;
      n_checks++; if (int_a !== 8'h08 || err !== 1'b1) begin n_errors++; $display("FAIL ar_pre: got %h/%b want 08/1", int_a, err); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (int_a !== 8'h00)  begin n_errors++; $display("FAIL ar_int_a: got %h want 00", int_a); end
      n_checks++; if (depth !== 4'd0)   begin n_errors++; $display("FAIL ar_depth: got %0d want 0", depth); end
      n_checks++; if (err !== 1'b0)     begin n_errors++; $display("FAIL ar_err: got %b want 0", err); end
      n_checks++; if (data_s !== 8'h00) begin n_errors++; $display("FAIL ar_data_s: got %h want 00", data_s); end
      model_reset();
      @(posedge clk); #1 reset = 1'b1;
   endtask

   task automatic test_random();
      logic [7:0] t;
      int r;
      for (int n = 0; n < 400; n++) begin
         if (n % 100 == 0) begin
            apply_reset();
            mask_we = 1'b1; mask_d = 8'($urandom); tick(); mask_we = 1'b0;
         end
         irq     = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         mask_we = ($urandom_range(0, 15) == 0);
         mask_d  = 8'($urandom);
         r = $urandom_range(0, 7);
         calli = '0;
         if (r < 3 && m_ds != 0) calli[top_line(m_ds)] = 1'b1;
         else if (r == 3) calli[$urandom_range(0, 7)] = 1'b1;
         r = $urandom_range(0, 7);
         t = '0;
         if (r < 2 && stk.size() > 0) t[stk[$]] = 1'b1;
         else if (r == 2) t[$urandom_range(0, 7)] = 1'b1;
         reti = t;
         tick();
         n_checks++; if (data_s !== m_ds) begin n_errors++; $display("FAIL rnd_data_s @%0d: got %h want %h", n, data_s, m_ds); end
         n_checks++; if (int_a !== m_int_a()) begin n_errors++; $display("FAIL rnd_int_a @%0d: got %h want %h", n, int_a, m_int_a()); end
         n_checks++; if (depth !== 4'(stk.size())) begin n_errors++; $display("FAIL rnd_depth @%0d: got %0d want %0d", n, depth, stk.size()); end
         n_checks++; if (err !== m_err) begin n_errors++; $display("FAIL rnd_err @%0d: got %b want %b", n, err, m_err); end
      end
      calli = '0; reti = '0; mask_we = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_nesting();
      test_mask();
      test_set_wins();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
